// File: rtl/score_keeper.sv
// Run score keeper: 4-digit BCD score, saturating speed level and milestone strobe.
// Optional session high score is built when HIGH_SCORE_EN is defined.
module score_keeper #(
    parameter int TICKS_PER_POINT = 4,
    parameter int MAX_LEVEL       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  game_tick,
    input  logic        game_start_pulse,
    input  logic        game_over_pulse,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [2:0]  speed_level,
    output logic        milestone_pulse,
    output logic        new_high_pulse,
    output logic        counting
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        FROZEN   = 2'd2
    } state_t;

    localparam logic [3:0]  PRESC_LAST = 4'(TICKS_PER_POINT - 1);
    localparam logic [2:0]  LEVEL_MAX  = 3'(MAX_LEVEL);
    localparam logic [15:0] SCORE_MAX  = 16'h9999;

    state_t      state;
    logic [3:0]  presc;
    logic [15:0] score_inc;
    logic        carry;
    logic        crash;

    // Frame tick has no role in scoring.
    logic unused_frame_tick;
    assign unused_frame_tick = &{1'b0, game_tick[0]};

    // BCD ripple increment: each 9 rolls to 0 and passes the carry up.
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (score[d*4 +: 4] == 4'd9) begin
                    score_inc[d*4 +: 4] = 4'd0;
                end else begin
                    score_inc[d*4 +: 4] = score[d*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    assign crash    = (state == COUNTING) && game_over_pulse && !game_start_pulse;
    assign counting = (state == COUNTING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            score           <= '0;
            presc           <= '0;
            speed_level     <= '0;
            milestone_pulse <= 1'b0;
        end else begin
            milestone_pulse <= 1'b0;
            if (game_start_pulse) begin
                state       <= COUNTING;
                score       <= '0;
                presc       <= '0;
                speed_level <= '0;
            end else begin
                case (state)
                    IDLE, FROZEN: ;
                    COUNTING: begin
                        if (game_over_pulse) begin
                            state <= FROZEN;
                        end else if (game_tick[1]) begin
                            if (presc == PRESC_LAST) begin
                                presc <= '0;
                                // At 9999 the score pins; the prescaler still wraps.
                                if (score != SCORE_MAX) begin
                                    score <= score_inc;
                                    if (score_inc[7:0] == 8'h00) begin
                                        milestone_pulse <= 1'b1;
                                        if (speed_level != LEVEL_MAX)
                                            speed_level <= speed_level + 3'd1;
                                    end
                                end
                            end else begin
                                presc <= presc + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        score       <= '0;
                        presc       <= '0;
                        speed_level <= '0;
                    end
                endcase
            end
        end
    end

`ifdef HIGH_SCORE_EN
    // BCD digits order like binary, so a plain unsigned compare is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_score     <= '0;
            new_high_pulse <= 1'b0;
        end else begin
            new_high_pulse <= 1'b0;
            if (crash && (score > high_score)) begin
                high_score     <= score;
                new_high_pulse <= 1'b1;
            end
        end
    end
`else
    logic unused_crash;
    assign unused_crash   = crash;
    assign high_score     = 16'h0000;
    assign new_high_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes model expectations, monitor pops and compares.
module tb_score_keeper;

    localparam int TPP  = 4;
    localparam int MAXL = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  game_tick = 2'b00;
    logic        game_start_pulse = 1'b0;
    logic        game_over_pulse = 1'b0;
    logic [15:0] score, high_score;
    logic [2:0]  speed_level;
    logic        milestone_pulse, new_high_pulse, counting;

    score_keeper #(.TICKS_PER_POINT(TPP), .MAX_LEVEL(MAXL)) dut (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick),
        .game_start_pulse(game_start_pulse), .game_over_pulse(game_over_pulse),
        .score(score), .high_score(high_score), .speed_level(speed_level),
        .milestone_pulse(milestone_pulse), .new_high_pulse(new_high_pulse),
        .counting(counting)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] score;
        logic [15:0] high;
        logic [2:0]  lvl;
        logic        ms;
        logic        nhp;
        logic        cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    // Reference model: plain integers; 0 idle, 1 running, 2 game over.
    int m_st = 0, m_score = 0, m_pres = 0, m_lvl = 0, m_high = 0;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(bit s, bit o, bit t1);
        exp_t x;
        @(negedge clk);
        game_start_pulse = s;
        game_over_pulse  = o;
        game_tick        = {t1, 1'($urandom_range(0, 1))};
        x.ms  = 1'b0;
        x.nhp = 1'b0;
        if (s) begin
            m_st = 1; m_score = 0; m_pres = 0; m_lvl = 0;
        end else if (m_st == 1 && o) begin
            m_st = 2;
`ifdef HIGH_SCORE_EN
            if (m_score > m_high) begin
                m_high = m_score;
                x.nhp  = 1'b1;
            end
`endif
        end else if (m_st == 1 && t1) begin
            m_pres = (m_pres + 1) % TPP;
            if (m_pres == 0 && m_score < 9999) begin
                m_score++;
                if (m_score % 100 == 0) begin
                    x.ms  = 1'b1;
                    m_lvl = (m_lvl < MAXL) ? m_lvl + 1 : MAXL;
                end
            end
        end
        x.score = to_bcd(m_score);
        x.high  = to_bcd(m_high);
        x.lvl   = 3'(m_lvl);
        x.cnt   = (m_st == 1);
        q.push_back(x);
    endtask

    task automatic ticks(int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_score", score, 16'h0000);
        chk("rst_high", high_score, 16'h0000);
        chk("rst_level", 16'(speed_level), 16'h0000);
        chk("rst_counting", 16'(counting), 16'h0000);
        m_st = 0; m_score = 0; m_pres = 0; m_lvl = 0; m_high = 0;
        game_tick = 2'b10;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        game_tick = 2'b00;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("score", score, e.score);
            chk("high_score", high_score, e.high);
            chk("speed_level", 16'(speed_level), 16'(e.lvl));
            chk("milestone_pulse", 16'(milestone_pulse), 16'(e.ms));
            chk("new_high_pulse", 16'(new_high_pulse), 16'(e.nhp));
            chk("counting", 16'(counting), 16'(e.cnt));
        end
    end

    initial begin
        #12;
        chk("init_score", score, 16'h0000);
        chk("init_level", 16'(speed_level), 16'h0000);
        chk("init_counting", 16'(counting), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle ignores ticks and crashes.
        ticks(5);
        cycle(1'b0, 1'b1, 1'b0);

        // 37 points, then a couple of quiet cycles.
        cycle(1'b1, 1'b0, 1'b0);
        ticks(TPP * 37);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Reach 42, reset asynchronously, ticks ignored until start.
        ticks(TPP * 5);
        async_reset();
        ticks(8);

        // Milestones and level saturation through 1000.
        cycle(1'b1, 1'b0, 1'b1);
        ticks(TPP * 99);
        ticks(TPP);
        ticks(TPP * 900);

        // Crash on the point-completing tick at 55, repeat, then a lower run.
        cycle(1'b1, 1'b0, 1'b0);
        ticks(TPP * 54 + TPP - 1);
        cycle(1'b0, 1'b1, 1'b1);
        ticks(6);
        cycle(1'b1, 1'b0, 1'b0);
        ticks(TPP * 54 + TPP - 1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        ticks(TPP * 30);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        // Saturate at 9999, crash, then start+over together while frozen.
        cycle(1'b1, 1'b0, 1'b0);
        ticks(TPP * 9999 + 20);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        ticks(8);

        // Random play.
        repeat (3000)
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
                  $urandom_range(0, 2) != 0);
        cycle(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
